// File: rtl/msdap_pkg.sv
// msdap_pkg: shared constants and types for the MSDAP output serializer.
//   DATA_W   - width of one channel result word
//   CNT_W    - width of the serial bit counter (2**CNT_W > DATA_W)
//   state_t  - serializer FSM states
//   LAST_BIT - counter value of the final serial bit in a frame
package msdap_pkg;

  localparam int DATA_W = 40;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

endpackage

// File: rtl/msdap_piso.sv
// msdap_piso: parallel-load, LSB-first shift register with a serial output.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset (register -> 0)
//   i_clear - synchronous flush (register -> 0)
//   i_load  - load i_data (has priority over i_shift)
//   i_shift - shift right by one, zero fill from the MSB side
//   i_data  - parallel word
//   o_sdo   - serial data out, always the current LSB
module msdap_piso
  import msdap_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_sdo
);

  logic [W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[W-1:1]};
    end
  end

  assign o_sdo = r_sr[0];

endmodule

// File: rtl/msdap_out_serializer.sv
// msdap_out_serializer: output stage of MSDAP. Accepts one left/right result
// pair per sample and shifts both out LSB first, framed by outReady.
// A frame is one lead cycle (data 0) followed by DATA_W data bits; outReady is
// low for at least one cycle between frames. A one-deep holding register takes
// a new pair while a frame is in flight; a pair arriving while it is full is
// dropped and sets the sticky overflow flag.
//
// Handshake: in_valid is a one-cycle strobe with no back-pressure. in_ready
// reports (registered) that the holding register is empty; a strobe while a
// frame is running and in_ready is low loses that word.
//
// Ports:
//   sclk        - system clock
//   reset       - synchronous active-high reset (also clears overflow)
//   clear       - synchronous flush of all data; overflow is kept
//   in_valid    - strobe: in_l/in_r hold a new result
//   in_l, in_r  - left / right result words
//   in_ready    - holding register empty
//   outReady    - frame strobe (lead cycle + DATA_W bit cycles)
//   outputL/R   - serial data, LSB first
//   overflow    - sticky: a result was dropped
//   o_dbg_state - current FSM state
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CW = CNT_W
) (
  input  logic          sclk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  output logic          in_ready,
  output logic          outReady,
  output logic          outputL,
  output logic          outputR,
  output logic          overflow,
  output state_t        o_dbg_state
);

  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        r_state,     w_state_nx;
  logic [CW-1:0] r_cnt,       w_cnt_nx;
  logic [DW-1:0] r_hold_l,    w_hold_l_nx;
  logic [DW-1:0] r_hold_r,    w_hold_r_nx;
  logic          r_hold_full, w_hold_full_nx;
  logic          r_in_ready;
  logic          r_out_ready, w_out_ready_nx;
  logic          r_out_l,     w_out_l_nx;
  logic          r_out_r,     w_out_r_nx;
  logic          r_overflow,  w_overflow_nx;

  logic          w_load;
  logic          w_shift;
  logic [DW-1:0] w_ld_l;
  logic [DW-1:0] w_ld_r;
  logic          w_sdo_l;
  logic          w_sdo_r;

  // The held word always goes out first; a fresh word only bypasses the
  // holding register when it is empty.
  assign w_ld_l = r_hold_full ? r_hold_l : in_l;
  assign w_ld_r = r_hold_full ? r_hold_r : in_r;

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_hold_l_nx    = r_hold_l;
    w_hold_r_nx    = r_hold_r;
    w_hold_full_nx = r_hold_full;
    w_out_ready_nx = 1'b0;
    w_out_l_nx     = 1'b0;
    w_out_r_nx     = 1'b0;
    w_overflow_nx  = r_overflow;
    w_load         = 1'b0;
    w_shift        = 1'b0;

    if (clear) begin
      // clear beats in_valid: the incoming word is discarded silently.
      w_state_nx     = ST_IDLE;
      w_cnt_nx       = '0;
      w_hold_l_nx    = '0;
      w_hold_r_nx    = '0;
      w_hold_full_nx = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_hold_full || in_valid) begin
            w_load         = 1'b1;
            w_state_nx     = ST_LEAD;
            w_out_ready_nx = 1'b1;
            // Held word is launched; a simultaneous new word takes its slot.
            if (r_hold_full) begin
              w_hold_full_nx = in_valid;
              if (in_valid) begin
                w_hold_l_nx = in_l;
                w_hold_r_nx = in_r;
              end
            end
          end
        end

        ST_LEAD, ST_SHIFT: begin
          w_out_ready_nx = 1'b1;
          w_out_l_nx     = w_sdo_l;
          w_out_r_nx     = w_sdo_r;
          w_shift        = 1'b1;
          if (r_state == ST_LEAD) begin
            w_state_nx = ST_SHIFT;
            w_cnt_nx   = '0;
          end else if (r_cnt == LAST) begin
            // Bit DW-1 is on the pins now; drop outReady next edge.
            w_state_nx     = ST_IDLE;
            w_cnt_nx       = '0;
            w_out_ready_nx = 1'b0;
            w_out_l_nx     = 1'b0;
            w_out_r_nx     = 1'b0;
            w_shift        = 1'b0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end

          if (in_valid) begin
            if (!r_hold_full) begin
              w_hold_l_nx    = in_l;
              w_hold_r_nx    = in_r;
              w_hold_full_nx = 1'b1;
            end else begin
              w_overflow_nx = 1'b1;
            end
          end
        end

        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_ready <= 1'b0;
      r_out_l     <= 1'b0;
      r_out_r     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_hold_l    <= w_hold_l_nx;
      r_hold_r    <= w_hold_r_nx;
      r_hold_full <= w_hold_full_nx;
      r_in_ready  <= !w_hold_full_nx;
      r_out_ready <= w_out_ready_nx;
      r_out_l     <= w_out_l_nx;
      r_out_r     <= w_out_r_nx;
      r_overflow  <= w_overflow_nx;
    end
  end

  msdap_piso #(.W(DW)) u_piso_l (
    .clk     (sclk),
    .reset   (reset),
    .i_clear (clear),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_ld_l),
    .o_sdo   (w_sdo_l)
  );

  msdap_piso #(.W(DW)) u_piso_r (
    .clk     (sclk),
    .reset   (reset),
    .i_clear (clear),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_ld_r),
    .o_sdo   (w_sdo_r)
  );

  assign in_ready    = r_in_ready;
  assign outReady    = r_out_ready;
  assign outputL     = r_out_l;
  assign outputR     = r_out_r;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: doc/msdap_out_serializer.md
Name: msdap_out_serializer

Overview:
Output stage of MSDAP_top, directly downstream of the filter ALU. It accepts one 40-bit left/right result pair per sample and shifts both channels out serially, LSB first, on sclk, framed by outReady. A one-deep holding register lets the ALU deliver the next result while the previous one is still shifting out.

Parameters:
DATA_W, 40, width of each channel result word.
CNT_W, 6, width of the bit counter; must satisfy 2^CNT_W > DATA_W.

Ports:
sclk  in  1  system clock, 26.88 MHz; the only clock.
reset  in  1  synchronous, active-high reset.
clear  in  1  synchronous abort from the main controller on a mid-stream reset or sleep; flushes all data.
in_valid  in  1  one-cycle strobe: in_l and in_r hold a new result.
in_l  in  DATA_W  left-channel result.
in_r  in  DATA_W  right-channel result.
in_ready  out  1  high when the holding register is empty.
outReady  out  1  output frame strobe.
outputL  out  1  left serial data.
outputR  out  1  right serial data.
overflow  out  1  sticky flag: a result was dropped.

Behaviour:
- Reset (and clear) force: state IDLE, holding register empty, shift registers 0, counter 0, outReady=0, outputL=outputR=0, in_ready=1. Only reset clears overflow; clear leaves it unchanged.
- clear has priority over in_valid in the same cycle. An in_valid arriving with clear is discarded and does not set overflow.
- All outputs are registered and change only on posedge sclk.
- States:
  - IDLE: if the holding register is full, or in_valid is high, load the shift registers and go to LEAD. The holding register has priority. If the holding register is full and in_valid is high in the same cycle, load the held word into the shift registers and store the new word in the holding register.
  - LEAD: outReady=1, outputL=outputR=0, lasts 1 cycle, then SHIFT with cnt=0.
  - SHIFT: outReady=1, outputL/R = bit cnt of the loaded words, cnt increments each cycle. After cnt==DATA_W-1, go to IDLE.
- Frame timing: outReady is high for exactly DATA_W+1 = 41 consecutive cycles: the lead cycle plus bits 0..39. It is low for at least 1 cycle between frames, even when the next word is already waiting. A consumer that sees outReady at a posedge samples bit k at the (k+1)-th following negedge.
- in_valid during LEAD or SHIFT: stored in the holding register if it is empty. If the holding register is full, the word is dropped, overflow is set to 1 and stays 1, and the holding register keeps the older word.
- in_ready = !holding_full, registered and updated in the same cycle as holding_full.
- in_valid in the final SHIFT cycle goes to the holding register. The next frame starts with the LEAD cycle that follows the 1 idle cycle.
- Worst-case throughput is 42 cycles per sample, well inside the 560 sclk cycles per sample (16 dclk at 768 kHz).
- clear during SHIFT: outReady drops at the next edge and the partial frame is abandoned. The consumer sees a short frame.

Decomposition:
- msdap_pkg: DATA_W=40 constant, state enum {IDLE, LEAD, SHIFT}, CNT_W.
- Sub-module msdap_piso: one DATA_W-bit parallel-load, LSB-first shift register with load/shift/clear controls and a serial output. Instantiate it twice (L and R). The FSM, counter and holding register stay in the top.

Test Plan:
1. Reset, then in_valid with in_l=40'h00000000FF and in_r=40'h8000000001 -> outReady high 41 cycles. After the lead cycle, outputL gives 1 for 8 bits then 0s; outputR gives bit0=1 and bit39=1, all others 0. After the frame, outReady=0 and outputs=0.
2. Back-to-back: in_valid A=40'h123456789A, then B=40'hFFFFFFFFFF 10 cycles later -> in_ready goes 0 after B. Frame A is 41 cycles, outReady is low exactly 1 cycle, then frame B is 41 cycles with all bits 1. in_ready returns to 1 when B loads. overflow stays 0.
3. Overflow: three in_valid strobes C, D, E during frame C -> D is kept, E is dropped, overflow=1 and stays 1 through frame D. The next frame carries D's bits.
4. clear asserted at SHIFT cnt=20 -> next cycle outReady=0, outputs=0, in_ready=1. No frame follows. overflow keeps its prior value.
5. Simultaneous in_valid and clear in IDLE -> no frame starts and overflow stays 0. reset mid-frame -> all outputs and overflow are 0 on the next cycle.
6. in_valid in the final SHIFT cycle (cnt=39) -> the word is held, 1 idle cycle follows, then a full 41-cycle frame.
